// File: rtl/seq_gen.sv
// Serial pattern transmitter: sends a captured pattern MSB-first, optionally repeated with a one-cycle gap.
// Define SEQ_GEN_PARITY_EN to append an even-parity bit to every frame.
module seq_gen #(
   parameter int unsigned PAT_W = 8,
   parameter int unsigned CNT_W = 4
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         start,
   input  logic [PAT_W-1:0]             pattern,
   input  logic [$clog2(PAT_W+1)-1:0]   len,
   input  logic [CNT_W-1:0]             repeat_n,
   output logic                         out,
   output logic                         out_valid,
   output logic                         busy,
   output logic                         done
);

   localparam int unsigned LEN_W = $clog2(PAT_W + 1);
   localparam int unsigned IDX_W = $clog2(PAT_W);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_GAP   = 2'd2;

   logic [1:0]       r_state, w_state_nxt;
   logic [PAT_W-1:0] r_pat, w_pat_nxt;
   logic [IDX_W-1:0] r_len_m1, w_len_m1_nxt;
   logic [IDX_W-1:0] r_idx, w_idx_nxt;
   logic [CNT_W-1:0] r_frames, w_frames_nxt;
   logic             r_out, w_out_nxt;
   logic             r_valid, w_valid_nxt;
   logic             r_busy, w_busy_nxt;
   logic             r_done, w_done_nxt;
   logic             w_frame_end;

   logic [LEN_W-1:0] w_eff_len;
   logic [IDX_W-1:0] w_len_m1;

`ifdef SEQ_GEN_PARITY_EN
   logic             r_par, w_par_nxt;
   logic             r_par_ph, w_par_ph_nxt;
   logic [PAT_W-1:0] w_mask;
`endif

   // Length 0 and anything beyond PAT_W both mean a full-width frame.
   always_comb begin
      w_eff_len = ((len == '0) || (len > LEN_W'(PAT_W))) ? LEN_W'(PAT_W) : len;
      w_len_m1  = IDX_W'(w_eff_len - LEN_W'(1));
`ifdef SEQ_GEN_PARITY_EN
      w_mask    = ~({PAT_W{1'b1}} << w_eff_len);
`endif
   end

   // Next-state and registered-output logic.
   always_comb begin
      w_state_nxt  = r_state;
      w_pat_nxt    = r_pat;
      w_len_m1_nxt = r_len_m1;
      w_idx_nxt    = r_idx;
      w_frames_nxt = r_frames;
      w_out_nxt    = 1'b0;
      w_valid_nxt  = 1'b0;
      w_busy_nxt   = 1'b0;
      w_done_nxt   = 1'b0;
      w_frame_end  = 1'b0;
`ifdef SEQ_GEN_PARITY_EN
      w_par_nxt    = r_par;
      w_par_ph_nxt = r_par_ph;
`endif

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_pat_nxt    = pattern;
               w_len_m1_nxt = w_len_m1;
               w_idx_nxt    = w_len_m1;
               w_frames_nxt = repeat_n;
               w_out_nxt    = pattern[w_len_m1];
               w_valid_nxt  = 1'b1;
               w_busy_nxt   = 1'b1;
               w_state_nxt  = S_SHIFT;
`ifdef SEQ_GEN_PARITY_EN
               w_par_nxt    = ^(pattern & w_mask);
               w_par_ph_nxt = 1'b0;
`endif
            end
         end

         S_SHIFT: begin
            w_busy_nxt = 1'b1;
`ifdef SEQ_GEN_PARITY_EN
            if (r_par_ph) begin
               w_frame_end = 1'b1;
            end else if (r_idx == '0) begin
               w_out_nxt    = r_par;
               w_valid_nxt  = 1'b1;
               w_par_ph_nxt = 1'b1;
            end else begin
               w_idx_nxt   = r_idx - IDX_W'(1);
               w_out_nxt   = r_pat[r_idx - IDX_W'(1)];
               w_valid_nxt = 1'b1;
            end
`else
            if (r_idx == '0) begin
               w_frame_end = 1'b1;
            end else begin
               w_idx_nxt   = r_idx - IDX_W'(1);
               w_out_nxt   = r_pat[r_idx - IDX_W'(1)];
               w_valid_nxt = 1'b1;
            end
`endif
            // Frame counter only decrements while nonzero, so it never wraps.
            if (w_frame_end) begin
               if (r_frames != '0) begin
                  w_frames_nxt = r_frames - CNT_W'(1);
                  w_state_nxt  = S_GAP;
               end else begin
                  w_busy_nxt  = 1'b0;
                  w_done_nxt  = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
         end

         S_GAP: begin
            w_busy_nxt   = 1'b1;
            w_idx_nxt    = r_len_m1;
            w_out_nxt    = r_pat[r_len_m1];
            w_valid_nxt  = 1'b1;
            w_state_nxt  = S_SHIFT;
`ifdef SEQ_GEN_PARITY_EN
            w_par_ph_nxt = 1'b0;
`endif
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state  <= S_IDLE;
         r_pat    <= '0;
         r_len_m1 <= '0;
         r_idx    <= '0;
         r_frames <= '0;
         r_out    <= 1'b0;
         r_valid  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
         r_par    <= 1'b0;
         r_par_ph <= 1'b0;
`endif
      end else begin
         r_state  <= w_state_nxt;
         r_pat    <= w_pat_nxt;
         r_len_m1 <= w_len_m1_nxt;
         r_idx    <= w_idx_nxt;
         r_frames <= w_frames_nxt;
         r_out    <= w_out_nxt;
         r_valid  <= w_valid_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
`ifdef SEQ_GEN_PARITY_EN
         r_par    <= w_par_nxt;
         r_par_ph <= w_par_ph_nxt;
`endif
      end
   end

   assign out       = r_out;
   assign out_valid = r_valid;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

// File: tb/tb_seq_gen.sv
// Directed bench for seq_gen: expected per-cycle {out,out_valid,busy,done} are queued at launch
// and popped one per clock; a small 1010 detector model checks the loopback case.
module tb_seq_gen;

   localparam int unsigned PAT_W = 8;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned LEN_W = 4;

   logic             clk = 1'b0;
   logic             rstn;
   logic             start;
   logic [PAT_W-1:0] pattern;
   logic [LEN_W-1:0] len;
   logic [CNT_W-1:0] repeat_n;
   logic             out;
   logic             out_valid;
   logic             busy;
   logic             done;

   logic [3:0]       q_exp[$];
   int               n_checks = 0;
   int               n_errors = 0;

   logic [3:0]       r_hist;
   logic             r_det;

   always #5 clk = ~clk;

   seq_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W)) u_dut (
      .clk       (clk),
      .rstn      (rstn),
      .start     (start),
      .pattern   (pattern),
      .len       (len),
      .repeat_n  (repeat_n),
      .out       (out),
      .out_valid (out_valid),
      .busy      (busy),
      .done      (done)
   );

   // Serial 1010 detector fed from the transmitter, with overlap.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_hist <= 4'b0;
         r_det  <= 1'b0;
      end else begin
         r_det <= out_valid && ({r_hist[2:0], out} == 4'b1010);
         if (out_valid) r_hist <= {r_hist[2:0], out};
      end
   end

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%b expected=%b", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] outs();
      return {out, out_valid, busy, done};
   endfunction

   // Expected timeline of one transmission, starting at cycle 1.
   function automatic void push_frames(input logic [7:0] pat, input logic [3:0] ln, input logic [3:0] rep);
      int   l;
      int   f;
      logic par;
      l   = ((ln == 4'd0) || (ln > 4'd8)) ? 8 : int'(ln);
      f   = int'(rep) + 1;
      par = 1'b0;
      for (int k = 0; k < l; k++) par = par ^ pat[k];
      for (int j = 0; j < f; j++) begin
         for (int k = l - 1; k >= 0; k--) q_exp.push_back({pat[k], 1'b1, 1'b1, 1'b0});
`ifdef SEQ_GEN_PARITY_EN
         q_exp.push_back({par, 1'b1, 1'b1, 1'b0});
`endif
         if (j < f - 1) q_exp.push_back(4'b0010);
      end
      q_exp.push_back(4'b0001);
   endfunction

   task automatic launch(input logic [7:0] pat, input logic [3:0] ln, input logic [3:0] rep);
      pattern  = pat;
      len      = ln;
      repeat_n = rep;
      start    = 1'b1;
      step();
      start    = 1'b0;
      push_frames(pat, ln, rep);
   endtask

   task automatic drain_n(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         if (q_exp.size() > 0) begin
            check(tag, outs(), q_exp.pop_front());
            step();
         end
      end
   endtask

   task automatic drain(input string tag);
      while (q_exp.size() > 0) begin
         check(tag, outs(), q_exp.pop_front());
         step();
      end
      check({tag, "_idle"}, outs(), 4'b0000);
   endtask

   initial begin
      int n1;
      int c;
      rstn     = 1'b0;
      start    = 1'b0;
      pattern  = '0;
      len      = '0;
      repeat_n = '0;
      step();
      step();
      check("reset", outs(), 4'b0000);
      rstn = 1'b1;
      step();
      check("idle", outs(), 4'b0000);

      launch(8'b1011_0010, 4'd8, 4'd0);
      drain("single");

      launch(8'h05, 4'd3, 4'd1);
      drain("repeat2");

      launch(8'hA5, 4'd0, 4'd0);
      drain("len0");

      launch(8'h01, 4'd1, 4'd0);
      drain("len1");

      launch(8'h3C, 4'd12, 4'd0);
      drain("clamp");

      launch(8'h02, 4'd2, 4'd15);
      drain("maxrep");

      // Second start and input changes mid-frame must not disturb the stream.
      launch(8'hC3, 4'd8, 4'd0);
      drain_n("busy_start", 3);
      start    = 1'b1;
      pattern  = 8'hFF;
      len      = 4'd2;
      repeat_n = 4'd3;
      drain_n("busy_start", 1);
      start    = 1'b0;
      drain("busy_start");

      // Start held through the done cycle launches a second frame immediately.
      pattern  = 8'h96;
      len      = 4'd4;
      repeat_n = 4'd0;
      start    = 1'b1;
      step();
      push_frames(8'h96, 4'd4, 4'd0);
      n1 = q_exp.size();
      push_frames(8'h96, 4'd4, 4'd0);
      drain_n("b2b", n1);
      start = 1'b0;
      drain("b2b");

      // Reset asserted during cycle 4 of an 8-bit frame.
      launch(8'hFF, 4'd8, 4'd0);
      drain_n("pre_rst", 3);
      rstn = 1'b0;
      step();
      check("rst_mid", outs(), 4'b0000);
      q_exp.delete();
      rstn = 1'b1;
      step();
      check("rst_no_done", outs(), 4'b0000);
      step();
      check("rst_no_done2", outs(), 4'b0000);
      launch(8'b1011_0010, 4'd8, 4'd0);
      drain("post_rst");

      // Loopback into the detector model.
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      step();
      launch(8'h0A, 4'd4, 4'd0);
      c = 1;
      while (q_exp.size() > 0) begin
         check("loop", outs(), q_exp.pop_front());
         check("loop_det", {3'b000, r_det}, {3'b000, (c == 5)});
         step();
         c++;
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/seq_gen.md
# seq_gen

Serial pattern transmitter: captures a parallel bit pattern on a start request and emits it one bit per clock on a registered serial output, optionally repeated with a one-cycle gap between frames. It is the stimulus/driver side of the team's serial sequence-detector FSMs. It sits upstream of a detector's `in` port and produces the bit streams those detectors recognise, with start/busy/done handshaking to a controller.

## Interface
- `PAT_W`, default 8: maximum pattern length in bits (≥2).
- `CNT_W`, default 4: width of the repeat counter.
- `clk`  input  1  single clock; all logic on the rising edge.
- `rstn`  input  1  reset, synchronous, active-low.
- `start`  input  1  request to transmit; sampled only in IDLE.
- `pattern`  input  PAT_W  bits to send, MSB-of-frame = `pattern[len-1]`.
- `len`  input  $clog2(PAT_W+1)  frame length in bits; 0 means PAT_W; values > PAT_W are clamped to PAT_W.
- `repeat_n`  input  CNT_W  extra frames; total frames = `repeat_n`+1.
- `out`  output  1  serial data bit (registered).
- `out_valid`  output  1  `out` carries a frame bit this cycle (registered).
- `busy`  output  1  high from the cycle after start is accepted through the last frame bit.
- `done`  output  1  one-cycle pulse, the cycle after the last frame bit.

## Operation
- States: IDLE, SHIFT, GAP.
- IDLE: `out`=0, `out_valid`=0, `busy`=0. On `start`=1, capture `pattern` into the shift register, the effective length into the bit counter, and `repeat_n` into the frame counter. Go to SHIFT.
- SHIFT: each cycle present the next bit, MSB-first from `pattern[len-1]` down to `pattern[0]`, with `out_valid`=1 and `busy`=1. After bit 0:
  - If frames remain, go to GAP and decrement the frame counter.
  - Otherwise, go to IDLE.
- GAP: exactly one cycle with `out`=0, `out_valid`=0, `busy`=1. The captured pattern is reloaded and the next cycle starts the next frame in SHIFT.
- Captured values are frozen. Changes on `pattern`, `len`, or `repeat_n` while busy have no effect.
- `start` while busy is ignored. It is not queued.
- `done`=1 for exactly one cycle, the first IDLE cycle after the final bit. `start` asserted in that cycle is accepted.
- `len`=1 is legal: a single-bit frame.
- `repeat_n` at its maximum gives 2^CNT_W frames. The counter must not wrap.

## Timing
- Reset: on a rising edge with `rstn`=0, the block goes to IDLE and `out`, `out_valid`, `busy`, `done` all become 0. This includes reset mid-frame; no `done` is produced for an aborted frame.
- Cycle numbering: edge E0 samples `start`=1.
- First bit is on `out` after E0 (cycle 1); latency from start is 1 cycle. Bit k of the frame appears in cycle k+1.
- `busy` rises in cycle 1.
- For an L-bit frame with F frames, the last bit is in cycle F·L + (F−1). In the next cycle, `done`=1 and `busy`=0.
- Gap cycles fall at cycles j·(L+1) for j = 1..F−1.

## Configuration
- `SEQ_GEN_PARITY_EN` defined:
  - After bit 0 of each frame, one extra bit is sent with `out_valid`=1: the even-parity bit (XOR of the L frame bits).
  - Effective frame length is L+1 in every timing formula above.
- Not defined: no parity bit; frames are exactly L bits.

## Test plan
- Single frame: `pattern`=8'b1011_0010, `len`=8, `repeat_n`=0, pulse `start`.
  - `out` = 1,0,1,1,0,0,1,0 in cycles 1–8 with `out_valid`=1.
  - `done`=1 and `busy`=0 in cycle 9.
  - With parity enabled: a 0 in cycle 9, and `done` in cycle 10.
- Short repeated frames: `pattern`=8'h05, `len`=3, `repeat_n`=1.
  - `out` = 1,0,1, then gap (cycle 4, `out_valid`=0), then 1,0,1 in cycles 5–7.
  - `done` in cycle 8.
  - With parity enabled: parity bit 0 after each frame, and `done` in cycle 10.
- `len`=0 with `pattern`=8'hA5: 8 bits 1,0,1,0,0,1,0,1 are sent.
  - With `len`=1 and `pattern[0]`=1: a single 1, then `done` in cycle 2.
- Start while busy, and back-to-back start:
  - A second `start` pulse during SHIFT produces no change to the stream.
  - `start` held high through the `done` cycle launches a new frame in the following cycle.
- Reset mid-frame: assert `rstn`=0 in cycle 4 of an 8-bit frame.
  - At that edge all outputs go to 0; no `done`.
  - After release, a new `start` transmits normally from cycle 1.
- Loopback: drive `out` into the team's serial detector with `pattern`=4'b1010, `len`=4.
  - The detector's output asserts exactly at the cycles expected from the sent sequence.
